// File: rtl/dp_ctrl_pkg.sv
// Shared types and width helpers for the serial datapath burst controller.
package dp_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dp_state_e;

    localparam int DP_LAT_DEFAULT = 21;

    function automatic int dp_len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int dp_cnt_w(input int max_len, input int lat);
        return $clog2(max_len + lat + 1);
    endfunction

endpackage

// File: rtl/dp_serdes.sv
// Serialiser/deserialiser for the 1-bit chain: registered drive mux and
// indexed capture register, both steered by the burst counter.
module dp_serdes
    import dp_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LAT     = DP_LAT_DEFAULT,
    localparam int LEN_W  = dp_len_w(MAX_LEN),
    localparam int CNT_W  = dp_cnt_w(MAX_LEN, LAT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   start_len,
    input  logic [MAX_LEN-1:0] start_pattern,
    input  logic               run,
    input  logic [CNT_W-1:0]   cnt,
    input  logic [LEN_W-1:0]   len,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic               dp_out,
    output logic               dp_in,
    output logic [MAX_LEN-1:0] res_data
);

    localparam int CMP_W = CNT_W + 1;

    logic               dp_in_d, dp_in_q;
    logic [MAX_LEN-1:0] res_data_d, res_data_q;
    logic [CMP_W-1:0]   nxt_idx, cap_idx, cnt_x, len_x;
    logic               drv_en, cap_en;

    // dp_in is registered, so the mux looks one bit ahead of cnt.
    always_comb begin
        cnt_x   = CMP_W'(cnt);
        len_x   = CMP_W'(len);
        nxt_idx = cnt_x + CMP_W'(1);
        cap_idx = cnt_x - CMP_W'(LAT);
        drv_en  = nxt_idx < len_x;
        cap_en  = (cnt_x >= CMP_W'(LAT)) && (cnt_x < len_x + CMP_W'(LAT));

        dp_in_d = 1'b0;
        if (start) begin
            if (start_len != '0) begin
                dp_in_d = start_pattern[0];
            end
        end else if (run && drv_en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (nxt_idx == CMP_W'(i)) begin
                    dp_in_d = pattern[i];
                end
            end
        end

        res_data_d = res_data_q;
        if (start) begin
            res_data_d = '0;
        end else if (run && cap_en) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                if (cap_idx == CMP_W'(i)) begin
                    res_data_d[i] = dp_out;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dp_in_q    <= 1'b0;
            res_data_q <= '0;
        end else begin
            dp_in_q    <= dp_in_d;
            res_data_q <= res_data_d;
        end
    end

    assign dp_in    = dp_in_q;
    assign res_data = res_data_q;

endmodule

// File: rtl/dp_burst_ctrl.sv
// Burst sequencer: accepts a pattern/length command, plays it through the
// serial chain, and holds the returned word until the consumer takes it.
module dp_burst_ctrl
    import dp_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 32,
    parameter int LAT     = DP_LAT_DEFAULT,
    localparam int LEN_W  = dp_len_w(MAX_LEN),
    localparam int CNT_W  = dp_cnt_w(MAX_LEN, LAT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_pattern,
    output logic               dp_in,
    input  logic               dp_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [MAX_LEN-1:0] res_data,
    output logic               busy
);

    localparam int CMP_W = CNT_W + 1;

    dp_state_e          state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [LEN_W-1:0]   len_d, len_q, len_sat;
    logic [MAX_LEN-1:0] pattern_d, pattern_q;
    logic               accept, last;

    assign accept  = (state_q == IDLE) && cmd_valid;
    assign len_sat = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign last    = CMP_W'(cnt_q) == CMP_W'(len_q) + CMP_W'(LAT - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_valid) state_d = (len_sat == '0) ? DONE : RUN;
            RUN:  if (last)      state_d = DONE;
            DONE: if (res_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state_q == IDLE);
        busy      = (state_q != IDLE);
        res_valid = (state_q == DONE);
    end

    // Counter parks at its final value so it can never wrap.
    always_comb begin
        len_d     = len_q;
        pattern_d = pattern_q;
        cnt_d     = cnt_q;
        if (accept) begin
            len_d     = len_sat;
            pattern_d = cmd_pattern;
            cnt_d     = '0;
        end else if ((state_q == RUN) && !last) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            len_q     <= '0;
            pattern_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            pattern_q <= pattern_d;
        end
    end

    dp_serdes #(
        .MAX_LEN (MAX_LEN),
        .LAT     (LAT)
    ) u_serdes (
        .clk           (clk),
        .rst           (rst),
        .start         (accept),
        .start_len     (len_sat),
        .start_pattern (cmd_pattern),
        .run           (state_q == RUN),
        .cnt           (cnt_q),
        .len           (len_q),
        .pattern       (pattern_q),
        .dp_out        (dp_out),
        .dp_in         (dp_in),
        .res_data      (res_data)
    );

endmodule

// File: tb/tb_dp_burst_ctrl.sv
// Scoreboard bench for dp_burst_ctrl driving a 21-stage chain stub.
module tb_dp_burst_ctrl;

    localparam int LAT = 21;

    typedef struct {
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_len;
    logic [31:0] cmd_pattern;
    logic        dp_in;
    logic        dp_out;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        busy;

    logic [LAT-1:0] chain;
    logic           invert;
    int             cyc = 0;
    int             n_checks = 0;
    int             n_fail = 0;
    exp_t           sb_q[$];

    dp_burst_ctrl #(.MAX_LEN(32), .LAT(LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_len     (cmd_len),
        .cmd_pattern (cmd_pattern),
        .dp_in       (dp_in),
        .dp_out      (dp_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) chain <= '0;
        else     chain <= {chain[LAT-2:0], dp_in};
    end
    assign dp_out = chain[LAT-1] ^ invert;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int len, input logic [31:0] pat, input logic [31:0] exp,
                        input int lat, input bit push, output int acc);
        int n;
        cmd_len     = 6'(len);
        cmd_pattern = pat;
        cmd_valid   = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: cmd_ready stuck at 0 for %0d cycles", n);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        if (push) sb_q.push_back('{data: exp, lat: lat, acc: acc});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!cmd_ready || sb_q.size() != 0) && n < 300);
        if (!cmd_ready || sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: cmd_ready=%0b pending=%0d", cmd_ready, sb_q.size());
        end
    endtask

    // Monitor: each rising res_valid must match the oldest expected result.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && res_valid === 1'b1 && !prev) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got res_data 0x%0h, expected no result", res_data);
                end else begin
                    e = sb_q.pop_front();
                    check("res_data", 64'(res_data), 64'(e.data));
                    check("res_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            prev = (res_valid === 1'b1);
        end
    end

    initial begin
        int acc, prev_acc, n;
        logic [3:0]  seq;
        logic [31:0] held;
        int          b_len[5];
        logic [31:0] b_pat[5];
        logic [31:0] b_exp[5];

        b_len = '{7, 13, 1, 32, 20};
        b_pat = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFE, 32'hA5A5_5A5A, 32'hCAFE_F00D};
        b_exp = '{32'h0000_006F, 32'h0000_1678, 32'h0000_0000, 32'hA5A5_5A5A, 32'h000E_F00D};

        rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_pattern = '0;
        res_ready = 1'b1; invert = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_dp_in", 64'(dp_in), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic burst with drive sequence
        seq = 4'b1011;
        send(4, 32'h0000_000B, 32'h0000_000B, 25, 1'b1, acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("drive_bit%0d", k), 64'(dp_in), 64'(seq[k]));
        end
        @(negedge clk);
        check("drive_tail_zero", 64'(dp_in), 64'd0);
        wait_idle();

        // Inverting stub, full length
        invert = 1'b1;
        send(32, 32'h0000_FFFF, 32'hFFFF_0000, 53, 1'b1, acc);
        wait_idle();
        invert = 1'b0;

        // Zero length, then saturation
        send(0, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1'b1, acc);
        wait_idle();
        send(40, 32'h1234_5678, 32'h1234_5678, 53, 1'b1, acc);
        wait_idle();

        // Backpressure
        res_ready = 1'b0;
        send(4, 32'h0000_0005, 32'h0000_0005, 25, 1'b1, acc);
        n = 0;
        while (res_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_res_valid_seen", 64'(res_valid), 64'd1);
        held = res_data;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 10) begin
                cmd_len = 6'd3; cmd_pattern = 32'h7; cmd_valid = 1'b1;
            end
            if (i == 60) cmd_valid = 1'b0;
            check("bp_res_valid", 64'(res_valid), 64'd1);
            check("bp_res_data", 64'(res_data), 64'(held));
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("bp_release_cmd_ready", 64'(cmd_ready), 64'd1);
        check("bp_release_res_valid", 64'(res_valid), 64'd0);
        check("bp_no_pending", 64'(sb_q.size()), 64'd0);
        res_ready = 1'b1;
        @(negedge clk);

        // Reset in cycle 10 of a 16-bit burst
        send(16, 32'h0000_FFFF, 32'h0, 0, 1'b0, acc);
        @(negedge clk);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_dp_in", 64'(dp_in), 64'd0);
        check("mid_rst_res_data", 64'(res_data), 64'd0);
        check("mid_rst_res_valid", 64'(res_valid), 64'd0);
        send(16, 32'h0000_BEEF, 32'h0000_BEEF, 37, 1'b1, acc);
        wait_idle();

        // Back-to-back with res_ready tied high
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(b_len[i], b_pat[i], b_exp[i], b_len[i] + LAT, 1'b1, acc);
            if (i > 0) check($sformatf("b2b_spacing%0d", i), 64'(acc - prev_acc), 64'(b_len[i-1] + LAT + 2));
            prev_acc = acc;
        end
        wait_idle();
        check("final_no_pending", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dp_burst_ctrl.md
# dp_burst_ctrl

Burst sequencer for the serial 1-bit datapath chain (clock/reset-shared `data_path` stages between `top.in` and `top.out`). It accepts a command carrying a bit pattern and length, serialises the pattern into the chain input, and waits the chain's fixed pipeline latency. It then deserialises the chain output into a result word and holds that word until a consumer takes it. It sits in the same clock domain as the datapath and replaces direct stimulus of the chain input.

## Interface
- `MAX_LEN`, 32, maximum burst length in bits; also the width of the pattern and result words.
- `LAT`, 21, cycles from a bit on `dp_in` to the same bit on `dp_out`. Must be ≥ 1. 21 is the sum of the default stage depths 10+1+10.
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  controller can accept a command.
- `cmd_len`  in  $clog2(MAX_LEN+1)  number of bits to send.
- `cmd_pattern`  in  MAX_LEN  bits to send, LSB first.
- `dp_in`  out  1  registered drive into the chain input.
- `dp_out`  in  1  chain output.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer takes the result.
- `res_data`  out  MAX_LEN  captured bits, LSB = first returned bit; unused bits are 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **FSM states**
  - IDLE: `cmd_ready`=1. On `cmd_valid` the controller latches `len` and `pattern`, clears `res_data` and `cnt`, and goes to RUN. If `cmd_len`==0 it goes to DONE instead.
  - RUN: `cnt` increments every cycle.
  - DONE: `res_valid`=1. On `res_ready` it goes to IDLE.
- **Length saturation:** `cmd_len` > MAX_LEN saturates to MAX_LEN.
- **Drive in RUN:** `dp_in` = `pattern[cnt]` while `cnt` < `len`, else 0. `dp_in` = 0 in IDLE and DONE.
- **Capture in RUN:** when `LAT` ≤ `cnt` < `len`+`LAT`, `res_data[cnt-LAT]` ← `dp_out`.
- **RUN exit:** RUN ends after the cycle with `cnt` == `len`+`LAT`-1, going to DONE.
- **Counter width:** `cnt` is $clog2(MAX_LEN+LAT+1) bits and never wraps.
- **Command blocking:** `cmd_ready`=0 in RUN and DONE; commands are not queued.
- **Simultaneous handshakes:** a DONE→IDLE transition and a new command cannot occur in the same cycle. The earliest next accept is the cycle after the `res_ready` handshake.
- **Result stability:** `res_data` is stable while `res_valid`=1.
- **Reset:** `rst` in any state, including mid-RUN, returns to IDLE next edge. The partial burst is discarded. Chain contents are not flushed by this block; the chain shares `rst`.

## Timing
- **Reset values:** `cmd_ready`=1, `dp_in`=0, `res_valid`=0, `res_data`=0, `busy`=0.
- **Cycle numbering:** the accept edge is edge E0. Cycle k is the k-th cycle after E0.
- **Drive timing:** `dp_in` carries `pattern[k]` in cycle k.
- **Capture timing:** `dp_out` is sampled at the end of cycle k+LAT into bit k.
- **Result timing:** `res_valid` rises in cycle `len`+`LAT`. For `len`=0 it rises in cycle 0.
- **Throughput:** at best one burst per `len`+`LAT`+2 cycles when `res_ready` is tied high.
- **Registered outputs:** all outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `dp_ctrl_pkg` holds:
  - the state enum `dp_state_e` {IDLE, RUN, DONE};
  - the `DP_LAT_DEFAULT`=21 localparam;
  - the width helper functions for the length and counter widths.
- Natural sub-module `dp_serdes`: the drive mux plus the capture shift/indexed register, controlled by `cnt`, `len` and a `run` enable. The FSM and counter stay in `dp_burst_ctrl`.

## Test plan
- **Basic burst:** use a 21-stage shift register as the chain stub. Send `cmd_len`=4, `cmd_pattern`=0xB. Required: `res_data`=0xB, `res_valid` first high in cycle 25, `dp_in` sequence 1,1,0,1 in cycles 0–3.
- **Inverting stub, full length:** chain stub is 21 stages followed by an inverter. Send `cmd_len`=32, pattern 0x0000_FFFF. Required: `res_data`=0xFFFF_0000, `res_valid` in cycle 53.
- **Zero length and saturation:** `cmd_len`=0 gives `res_valid` in cycle 0 with `res_data`=0. `cmd_len`=40 with `MAX_LEN`=32 runs 32 bits, with `res_valid` in cycle 53.
- **Backpressure:** hold `res_ready`=0 for 100 cycles after `res_valid`. Required: `res_valid` and `res_data` stable, `cmd_ready`=0, and a `cmd_valid` offered during this time is ignored. Then `res_ready`=1 for one cycle, after which `cmd_ready`=1 on the next cycle.
- **Reset mid-run:** assert `rst` in cycle 10 of a 16-bit burst. Required: next cycle IDLE, `busy`=0, `dp_in`=0, `res_data`=0, no `res_valid`. A following burst then completes correctly.
- **Back-to-back:** run 5 random bursts with `res_ready` tied high. Each result must equal its pattern masked to `len` bits, and successive accepts must be exactly `len`+`LAT`+2 cycles apart.
